// File: rtl/led_blink_stretcher_if.sv
// Event strobe in, LED drive and queue status out, for led_blink_stretcher.
interface led_blink_stretcher_if #(
  parameter int PEND_W = 4
);
  logic              event_in;
  logic              led_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (
    output event_in,
    input  led_out,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  event_in,
    output led_out,
    output busy,
    output pending,
    output overflow
  );
endinterface

// File: rtl/led_blink_stretcher.sv
// Stretches single-cycle events into LED blinks with minimum on/off times.
// Define LED_BLINK_QUEUE_EN to build the pending-event replay counter.
module led_blink_stretcher #(
  parameter int ON_CYCLES  = 75,
  parameter int OFF_CYCLES = 75,
  parameter int CNT_W      = 20,
  parameter int PEND_W     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  led_blink_stretcher_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             led_q;
  logic             busy_q;
  logic             off_last_s;
  logic             pend_nz_s;

  assign off_last_s = (timer_q == OFF_LAST);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + CNT_W'(1);
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (bus.event_in) begin
          state_d = S_ON;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ON: begin
        if (timer_q == ON_LAST) begin
          state_d = S_OFF;
          timer_d = '0;
        end else begin
          state_d = S_ON;
        end
      end
      S_OFF: begin
        if (off_last_s) begin
          timer_d = '0;
          if (pend_nz_s || bus.event_in) begin
            state_d = S_ON;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_OFF;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      led_q   <= (state_d == S_ON);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign bus.led_out = led_q;
  assign bus.busy    = busy_q;

`ifdef LED_BLINK_QUEUE_EN
  localparam logic [PEND_W:0] PEND_MAX = {1'b0, {PEND_W{1'b1}}};

  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              dec_q;
  logic              carry_q;
  logic              queue_ev_s;
  logic              chain_q_s;
  logic [1:0]        add_s;
  logic [PEND_W:0]   sum_s;

  assign queue_ev_s = bus.event_in &
                      ((state_q == S_ON) || ((state_q == S_OFF) && !off_last_s));
  assign chain_q_s  = (state_q == S_OFF) && off_last_s && pend_nz_s;
  assign pend_nz_s  = (pend_q != '0);

  // The replay decrement lands in the first ON cycle; an event on the chaining
  // OFF cycle is carried alongside it so the two can cancel.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    add_s  = {1'b0, queue_ev_s} + {1'b0, carry_q};
    sum_s  = {1'b0, pend_q} + (PEND_W + 1)'(add_s) - (PEND_W + 1)'(dec_q);
    if (sum_s > PEND_MAX) begin
      pend_d = pend_q;
      ovf_d  = 1'b1;
    end else begin
      pend_d = sum_s[PEND_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      dec_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      dec_q   <= chain_q_s;
      carry_q <= chain_q_s & bus.event_in;
    end
  end

  assign bus.pending  = pend_q;
  assign bus.overflow = ovf_q;
`else
  assign pend_nz_s    = 1'b0;
  assign bus.pending  = '0;
  assign bus.overflow = 1'b0;
`endif

endmodule

// File: tb/tb_led_blink_stretcher.sv
// Directed scoreboard bench for led_blink_stretcher (ON=4, OFF=3, PEND_W=2).
module tb_led_blink_stretcher;

  typedef struct packed {
    logic       led;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;
  } exp_t;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;
  exp_t sb[$];

  led_blink_stretcher_if #(.PEND_W(2)) bus ();

  led_blink_stretcher #(
    .ON_CYCLES (4),
    .OFF_CYCLES(3),
    .CNT_W     (4),
    .PEND_W    (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic in_rng(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  function automatic logic ev_at(input int s, input int i);
    case (s)
      0:       return (i < 2);
      1:       return (i == 10);
      2:       return (i == 10) || (i == 12);
      3:       return (i == 10) || (i == 12) || (i == 14) || (i == 16);
      4:       return (i == 10) || (i == 17);
      5:       return (i == 10) || (i == 12) || (i == 13) || (i == 14);
      6:       return (i >= 10) && (i <= 15);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic rst_at(input int s, input int i);
    case (s)
      0:       return (i < 2);
      2:       return (i == 12);
      default: return 1'b0;
    endcase
  endfunction

  // Expected outputs observed in cycle c of scenario s
  function automatic exp_t exp_at(input int s, input int c);
    exp_t e;
    e = '0;
    case (s)
      1, 3: begin
        e.led  = in_rng(c, 11, 14);
        e.busy = in_rng(c, 11, 17);
      end
      2: begin
        e.led  = in_rng(c, 11, 12);
        e.busy = in_rng(c, 11, 12);
      end
      4: begin
        e.led  = in_rng(c, 11, 14) || in_rng(c, 18, 21);
        e.busy = in_rng(c, 11, 24);
      end
      5, 6: begin
        e.led  = in_rng(c, 11, 14) || in_rng(c, 18, 21) ||
                 in_rng(c, 25, 28) || in_rng(c, 32, 35);
        e.busy = in_rng(c, 11, 38);
        if (s == 5) begin
          if (c == 13)      e.pend = 2'd1;
          else if (c == 14) e.pend = 2'd2;
          else if (in_rng(c, 15, 18)) e.pend = 2'd3;
          else if (in_rng(c, 19, 25)) e.pend = 2'd2;
          else if (in_rng(c, 26, 32)) e.pend = 2'd1;
          else              e.pend = 2'd0;
        end else begin
          if (c == 12)      e.pend = 2'd1;
          else if (c == 13) e.pend = 2'd2;
          else if (in_rng(c, 14, 18)) e.pend = 2'd3;
          else if (in_rng(c, 19, 25)) e.pend = 2'd2;
          else if (in_rng(c, 26, 32)) e.pend = 2'd1;
          else              e.pend = 2'd0;
          e.ovf = (c >= 15);
        end
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input int s, input int c,
                       input logic [3:0] obs, input logic [3:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s scen=%0d cycle=%0d observed=%0h expected=%0h", tag, s, c, obs, exp_v);
    end
  endtask

  task automatic drive(input logic ev, input logic rs, input exp_t e,
                       input int s, input int c);
    exp_t got;
    sb.push_back(e);
    bus.event_in = ev;
    reset        = rs;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("led_out",  s, c, {3'b000, bus.led_out},  {3'b000, got.led});
    check("busy",     s, c, {3'b000, bus.busy},     {3'b000, got.busy});
    check("pending",  s, c, {2'b00, bus.pending},   {2'b00, got.pend});
    check("overflow", s, c, {3'b000, bus.overflow}, {3'b000, got.ovf});
  endtask

  task automatic run_scen(input int s, input int len);
    drive(1'b0, 1'b1, exp_t'('0), s, -1);
    for (int i = 0; i < len; i++) begin
      drive(ev_at(s, i), rst_at(s, i), exp_at(s, i + 1), s, i + 1);
    end
  endtask

  initial begin
    clk          = 1'b0;
    reset        = 1'b1;
    bus.event_in = 1'b0;
    n_assert     = 0;
    n_fail       = 0;
    @(negedge clk);
    run_scen(0, 15);
    run_scen(1, 20);
    run_scen(2, 18);
`ifdef LED_BLINK_QUEUE_EN
    run_scen(5, 42);
    run_scen(6, 42);
`else
    run_scen(3, 21);
`endif
    run_scen(4, 27);
    drive(1'b0, 1'b1, exp_t'('0), 7, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
